car_detect: RTL and testbench

CAR_DETECT -- requirements
Module: car_detect

---
 rtl/car_detect.sv | 124 ++++++++++++
 tb/tb_car_detect.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/car_detect.sv
// car_detect: conditions the east-west and north-south loop detectors for the
// light controller. Each direction runs an identical, independent channel:
// two-flop synchronizer -> debounce filter -> arrival edge detect -> pending
// service request. The request is raised on an arrival and dropped once the
// direction has been green while the loop reads empty.
// Optional build macro CAR_DETECT_STATS_EN adds saturating 8-bit arrival
// counters on EWCount / NSCount.

module car_detect #(
    parameter int DEBOUNCE = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       EWSense,
    input  logic       NSSense,
    input  logic       EWLite,
    input  logic       NSLite,
    output logic       EWCar,
    output logic       NSCar
`ifdef CAR_DETECT_STATS_EN
    ,
    output logic [7:0] EWCount,
    output logic [7:0] NSCount
`endif
);

    // Debounce counter only has to reach DEBOUNCE-1 before it clears.
    localparam int             CW       = $clog2(DEBOUNCE);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE - 1);

    // Channel 0 is east-west, channel 1 is north-south.
    logic [1:0] sense;
    logic [1:0] lite;
    logic [1:0] car;

    assign sense = {NSSense, EWSense};
    assign lite  = {NSLite,  EWLite};

    assign EWCar = car[0];
    assign NSCar = car[1];

`ifdef CAR_DETECT_STATS_EN
    logic [7:0] count_all [2];

    assign EWCount = count_all[0];
    assign NSCount = count_all[1];
`endif

    for (genvar g = 0; g < 2; g++) begin : g_chan
        logic          sync_p0;
        logic          sync_p1;
        logic          filt_p2;
        logic          filt_p3;
        logic [CW-1:0] cnt_p2;
        logic          pend;
        logic          arrive;
        logic          served;

        // Two-flop synchronizer for the detector, which is asynchronous to clock.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                sync_p0 <= 1'b0;
                sync_p1 <= 1'b0;
            end else begin
                sync_p0 <= sense[g];
                sync_p1 <= sync_p0;
            end
        end

        // Filtered level flips only after DEBOUNCE consecutive disagreeing samples.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                cnt_p2  <= '0;
                filt_p2 <= 1'b0;
            end else if (sync_p1 == filt_p2) begin
                cnt_p2  <= '0;
            end else if (cnt_p2 == CNT_LAST) begin
                cnt_p2  <= '0;
                filt_p2 <= ~filt_p2;
            end else begin
                cnt_p2  <= cnt_p2 + 1'b1;
            end
        end

        // A rising filtered level is an arrival; green with an empty loop means
        // the car has been served and left. A car sitting on green keeps its
        // request because served needs the loop to read empty.
        assign arrive = filt_p2 & ~filt_p3;
        assign served = lite[g] & ~filt_p2;

        // Edge-detect history plus the pending request; an arrival beats a clear.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                filt_p3 <= 1'b0;
                pend    <= 1'b0;
            end else begin
                filt_p3 <= filt_p2;
                if (arrive) begin
                    pend <= 1'b1;
                end else if (served) begin
                    pend <= 1'b0;
                end
            end
        end

        assign car[g] = pend;

`ifdef CAR_DETECT_STATS_EN
        logic [7:0] count;

        // Arrival counter that sticks at 255 instead of wrapping.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                count <= 8'd0;
            end else if (arrive && (count != 8'hFF)) begin
                count <= count + 8'd1;
            end
        end

        assign count_all[g] = count;
`endif
    end

endmodule

// File: tb/tb_car_detect.sv
// tb_car_detect: directed scenarios plus random stimulus for car_detect,
// checked every cycle against a window-based behavioural model.

module tb_car_detect;

    localparam int D = 4;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic EWSense = 1'b0;
    logic NSSense = 1'b0;
    logic EWLite  = 1'b0;
    logic NSLite  = 1'b0;
    logic EWCar;
    logic NSCar;
`ifdef CAR_DETECT_STATS_EN
    logic [7:0] EWCount;
    logic [7:0] NSCount;
`endif

    always #5 clock = ~clock;

    car_detect #(.DEBOUNCE(D)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .EWSense (EWSense),
        .NSSense (NSSense),
        .EWLite  (EWLite),
        .NSLite  (NSLite),
        .EWCar   (EWCar),
        .NSCar   (NSCar)
`ifdef CAR_DETECT_STATS_EN
        ,
        .EWCount (EWCount),
        .NSCount (NSCount)
`endif
    );

    int nchk = 0;
    int nerr = 0;

    // Reference model: raw sample history per direction (index 0 = newest edge).
    bit h [2][64];
    bit m_filt  [2];
    bit m_fprev [2];
    bit m_pend  [2];
    int m_cnt   [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 64; k++) h[c][k] = 1'b0;
            m_filt[c]  = 1'b0;
            m_fprev[c] = 1'b0;
            m_pend[c]  = 1'b0;
            m_cnt[c]   = 0;
        end
    endtask

    // One rising edge: the filtered level flips when the DEBOUNCE synchronized
    // samples seen before this edge (raw taken 2..D+1 edges ago) all disagree.
    task automatic model_edge();
        bit raw, lt, arrive, served, all_diff, newp;
        for (int c = 0; c < 2; c++) begin
            raw = (c == 0) ? EWSense : NSSense;
            lt  = (c == 0) ? EWLite  : NSLite;
            for (int k = 63; k > 0; k--) h[c][k] = h[c][k-1];
            h[c][0] = raw;
            arrive = m_filt[c] && !m_fprev[c];
            served = lt && !m_filt[c];
            all_diff = 1'b1;
            for (int k = 2; k <= D + 1; k++) if (h[c][k] == m_filt[c]) all_diff = 1'b0;
            newp = arrive ? 1'b1 : (served ? 1'b0 : m_pend[c]);
            if (arrive && m_cnt[c] < 255) m_cnt[c]++;
            m_fprev[c] = m_filt[c];
            if (all_diff) m_filt[c] = !m_filt[c];
            m_pend[c] = newp;
        end
    endtask

    task automatic compare_all();
        check("EWCar model", EWCar, m_pend[0]);
        check("NSCar model", NSCar, m_pend[1]);
`ifdef CAR_DETECT_STATS_EN
        check("EWCount model", EWCount, m_cnt[0]);
        check("NSCount model", NSCount, m_cnt[1]);
`endif
    endtask

    // Advance n edges; inputs are changed only between calls (at a falling edge).
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            model_edge();
            @(negedge clock);
            compare_all();
        end
    endtask

    // Asynchronous reset pulse between edges, checked before the next edge.
    task automatic mid_reset();
        #1 reset_n = 1'b0;
        #1;
        check("reset EWCar", EWCar, 0);
        check("reset NSCar", NSCar, 0);
`ifdef CAR_DETECT_STATS_EN
        check("reset EWCount", EWCount, 0);
        check("reset NSCount", NSCount, 0);
`endif
        model_reset();
        #1 reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(negedge clock);
        @(negedge clock);
        check("por EWCar", EWCar, 0);
        check("por NSCar", NSCar, 0);
        reset_n = 1'b1;

        // EW arrival latency: low through edge D+2, high after edge D+3.
        EWSense = 1'b1;
        for (int i = 1; i <= D + 3; i++) begin
            step(1);
            check("ew latency", EWCar, (i < D + 3) ? 0 : 1);
            check("ns idle", NSCar, 0);
        end

        // Car waiting on green keeps its request; falls D+3 edges after leaving.
        EWLite = 1'b1;
        step(5);
        check("ew hold on green", EWCar, 1);
        EWSense = 1'b0;
        for (int i = 1; i <= D + 3; i++) begin
            step(1);
            check("ew depart", EWCar, (i < D + 3) ? 1 : 0);
        end
        EWLite = 1'b0;

        // Request survives an empty loop until green arrives.
        EWSense = 1'b1;
        step(D + 4);
        check("ew rearrive", EWCar, 1);
        EWSense = 1'b0;
        step(20);
        check("ew wait red", EWCar, 1);
        EWLite = 1'b1;
        step(1);
        check("ew served", EWCar, 0);
        EWLite = 1'b0;

        // Short NS glitches never pass the debounce filter.
        for (int r = 0; r < 6; r++) begin
            NSSense = 1'b1;
            step(3);
            check("ns glitch hi", NSCar, 0);
            NSSense = 1'b0;
            step(3);
            check("ns glitch lo", NSCar, 0);
        end
`ifdef CAR_DETECT_STATS_EN
        check("ns glitch count", NSCount, 0);
`endif

        // Both directions requested, then reset mid-cycle with inputs held high.
        EWSense = 1'b1;
        NSSense = 1'b1;
        step(D + 4);
        check("both set EW", EWCar, 1);
        check("both set NS", NSCar, 1);
        mid_reset();
        for (int i = 1; i <= D + 3; i++) begin
            step(1);
            check("post-reset EW", EWCar, (i < D + 3) ? 0 : 1);
            check("post-reset NS", NSCar, (i < D + 3) ? 0 : 1);
        end
        EWSense = 1'b0;
        NSSense = 1'b0;
        EWLite  = 1'b1;
        NSLite  = 1'b1;
        step(D + 6);
        check("both cleared EW", EWCar, 0);
        check("both cleared NS", NSCar, 0);
        EWLite = 1'b0;
        NSLite = 1'b0;

        // Random traffic and light feedback against the model.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 5) == 0) EWSense = ~EWSense;
            if ($urandom_range(0, 5) == 0) NSSense = ~NSSense;
            if ($urandom_range(0, 9) == 0) EWLite  = ~EWLite;
            if ($urandom_range(0, 9) == 0) NSLite  = ~NSLite;
            step(1);
        end

`ifdef CAR_DETECT_STATS_EN
        // 300 clean EW arrivals saturate the counter at 255.
        EWSense = 1'b0;
        NSSense = 1'b0;
        EWLite  = 1'b1;
        NSLite  = 1'b1;
        mid_reset();
        for (int i = 0; i < 300; i++) begin
            EWSense = 1'b1;
            step(D + 4);
            EWSense = 1'b0;
            step(D + 4);
        end
        check("ew count sat", EWCount, 255);
        check("ns count idle", NSCount, 0);
        step(10);
        check("ew count hold", EWCount, 255);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
